// File: rtl/usb_rx_rcu.sv
// Receiver control unit for the USB RX path: validates SYNC/PID, strobes one
// FIFO write per payload byte, bounds payload length and sequences EOP.
module usb_rx_rcu #(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] wr_data,
  output logic [3:0] rx_pid,
  output logic [6:0] byte_count,
  output logic       rx_done,
  output logic       r_error
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PID,
    DATA,
    STORE,
    EOP_WAIT,
    DONE,
    ERR
  } state_t;

  state_t state, next_state;
  logic   err_eop_seen;
  logic   capture_pid;
  logic   capture_byte;
  logic   pid_ok;

  assign pid_ok = (rcv_data[7:4] == ~rcv_data[3:0]);

  // eop has priority over a coincident byte in every receiving state
  always_comb begin
    next_state   = state;
    capture_pid  = 1'b0;
    capture_byte = 1'b0;
    case (state)
      IDLE:     if (d_edge) next_state = SYNC;
      SYNC: begin
        if (eop) next_state = ERR;
        else if (byte_received) next_state = (rcv_data == 8'h80) ? PID : ERR;
      end
      PID: begin
        if (eop) next_state = ERR;
        else if (byte_received) begin
          if (pid_ok) begin
            capture_pid = 1'b1;
            next_state  = DATA;
          end else begin
            next_state = ERR;
          end
        end
      end
      DATA: begin
        if (eop) next_state = EOP_WAIT;
        else if (byte_received) begin
          if (byte_count == MAX_CNT) begin
            next_state = ERR;
          end else begin
            capture_byte = 1'b1;
            next_state   = STORE;
          end
        end
      end
      STORE:    next_state = DATA;
      EOP_WAIT: if (!eop) next_state = DONE;
      DONE:     next_state = IDLE;
      ERR:      if (err_eop_seen && !eop) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      err_eop_seen <= 1'b0;
      wr_data      <= 8'h00;
      rx_pid       <= 4'h0;
      byte_count   <= 7'd0;
      r_error      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && d_edge) begin
        r_error    <= 1'b0;
        byte_count <= 7'd0;
      end
      // ERR may only exit after eop has been observed high, then low
      if (next_state == ERR && state != ERR) begin
        r_error      <= 1'b1;
        err_eop_seen <= 1'b0;
      end else if (state == ERR && eop) begin
        err_eop_seen <= 1'b1;
      end
      if (capture_pid) rx_pid <= rcv_data[3:0];
      if (capture_byte) wr_data <= rcv_data;
      if (state == STORE) byte_count <= byte_count + 7'd1;
    end
  end

  assign rcving   = (state != IDLE) && (state != DONE);
  assign w_enable = (state == STORE);
  assign rx_done  = (state == DONE);

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Scoreboard bench for usb_rx_rcu: packet-level reference model pushes expected
// writes and packet endings; a monitor pops them as the DUT presents outputs.
module tb_usb_rx_rcu;

  localparam int MAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_edge;
  logic       eop;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic [7:0] wr_data;
  logic [3:0] rx_pid;
  logic [6:0] byte_count;
  logic       rx_done;
  logic       r_error;

  usb_rx_rcu #(.MAX_BYTES(MAX)) dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop),
    .byte_received(byte_received), .rcv_data(rcv_data),
    .rcving(rcving), .w_enable(w_enable), .wr_data(wr_data),
    .rx_pid(rx_pid), .byte_count(byte_count), .rx_done(rx_done),
    .r_error(r_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [6:0] idx;
  } wr_t;

  typedef struct {
    bit         is_err;
    logic [3:0] pid;
    logic [6:0] count;
  } ev_t;

  wr_t        wq[$];
  ev_t        eq[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] model_pid = 4'h0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    for (int i = 0; i < 8; i++) begin
      d_edge = ($urandom_range(0, 3) == 0);
      tick();
    end
    d_edge = 1'b0;
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    byte_received = 1'b1;
    rcv_data      = b;
    tick();
    byte_received = 1'b0;
    rcv_data      = 8'($urandom);
  endtask

  // Expected outcome computed from the packet as a whole
  task automatic model_packet(input logic [7:0] b[$], input bit collide);
    ev_t        ev;
    logic [7:0] pb;
    int         pay_n;
    ev.is_err = 1'b1;
    ev.count  = 7'd0;
    ev.pid    = model_pid;
    if (b.size() < 1 || b[0] != 8'h80) begin
      eq.push_back(ev);
      return;
    end
    if (b.size() < 2) begin
      eq.push_back(ev);
      return;
    end
    pb = b[1];
    if (pb[7:4] != ~pb[3:0]) begin
      eq.push_back(ev);
      return;
    end
    model_pid = pb[3:0];
    ev.pid    = model_pid;
    pay_n     = b.size() - 2 - (collide ? 1 : 0);
    for (int k = 0; k < pay_n && k < MAX; k++) begin
      wr_t w;
      w.data = b[k+2];
      w.idx  = 7'(k);
      wq.push_back(w);
    end
    if (pay_n > MAX) begin
      ev.count = 7'(MAX);
    end else begin
      ev.is_err = 1'b0;
      ev.count  = 7'(pay_n);
    end
    eq.push_back(ev);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((wq.size() != 0 || eq.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, 32'(wq.size() + eq.size()), 32'd0);
    wq.delete();
    eq.delete();
  endtask

  task automatic applyStimulus(input string name, input logic [7:0] b[$], input bit collide);
    model_packet(b, collide);
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    chk({name, "_rcving_rise"}, 32'(rcving), 32'd1);
    chk({name, "_err_clear"}, 32'(r_error), 32'd0);
    tick();
    tick();
    for (int i = 0; i < b.size(); i++) begin
      if (collide && i == b.size() - 1) begin
        byte_received = 1'b1;
        rcv_data      = b[i];
        eop           = 1'b1;
        tick();
        byte_received = 1'b0;
        tick();
        eop = 1'b0;
      end else begin
        pulse_byte(b[i]);
        gap();
      end
    end
    if (!collide) begin
      eop = 1'b1;
      tick();
      tick();
      eop = 1'b0;
    end
    repeat (6) tick();
    chk({name, "_idle"}, 32'(rcving), 32'd0);
    wait_drain(name);
  endtask

  task automatic checkOutput(input string name);
    chk({name, "_rcving"}, 32'(rcving), 32'd0);
    chk({name, "_w_enable"}, 32'(w_enable), 32'd0);
    chk({name, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({name, "_rx_pid"}, 32'(rx_pid), 32'd0);
    chk({name, "_byte_count"}, 32'(byte_count), 32'd0);
    chk({name, "_rx_done"}, 32'(rx_done), 32'd0);
    chk({name, "_r_error"}, 32'(r_error), 32'd0);
  endtask

  // Monitor: every presented output must match the head of its queue
  initial begin
    logic prev_err;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (w_enable) begin
          if (wq.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
          end else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_data", 32'(wr_data), 32'(w.data));
            chk("wr_index", 32'(byte_count), 32'(w.idx));
          end
        end
        if (rx_done || (r_error && !prev_err)) begin
          if (eq.size() == 0) begin
            chk("unexpected_end", 32'd1, 32'd0);
          end else begin
            ev_t ev;
            ev = eq.pop_front();
            chk("end_is_error", 32'(r_error && !rx_done), 32'(ev.is_err));
            chk("end_pid", 32'(rx_pid), 32'(ev.pid));
            chk("end_count", 32'(byte_count), 32'(ev.count));
          end
        end
      end
      prev_err = r_error;
    end
  end

  initial begin
    logic [7:0] pkt[$];
    rst = 1'b1; d_edge = 1'b0; eop = 1'b0; byte_received = 1'b0; rcv_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset");
    mon_en = 1'b1;
    tick();

    applyStimulus("data0", '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33}, 1'b0);
    chk("data0_pid", 32'(rx_pid), 32'h3);
    chk("data0_count", 32'(byte_count), 32'd3);
    applyStimulus("bad_sync", '{8'h81, 8'hC3, 8'h44}, 1'b0);
    chk("bad_sync_err", 32'(r_error), 32'd1);
    applyStimulus("bad_pid", '{8'h80, 8'hC4, 8'h55}, 1'b0);
    chk("bad_pid_keep", 32'(rx_pid), 32'h3);
    applyStimulus("overflow", '{8'h80, 8'hE1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 1'b0);
    chk("overflow_count", 32'(byte_count), 32'd4);
    applyStimulus("token", '{8'h80, 8'h69}, 1'b0);
    chk("token_count", 32'(byte_count), 32'd0);
    applyStimulus("collide", '{8'h80, 8'h4B, 8'hAA}, 1'b1);
    applyStimulus("early_eop", '{8'h80}, 1'b0);

    // Reset in the middle of the payload
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    tick();
    pulse_byte(8'h80);
    gap();
    pulse_byte(8'hD2);
    gap();
    begin
      wr_t w;
      w.data = 8'h5A;
      w.idx  = 7'd0;
      wq.push_back(w);
    end
    pulse_byte(8'h5A);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("mid_reset");
    rst = 1'b0;
    model_pid = 4'h0;
    repeat (12) tick();
    chk("mid_reset_queue", 32'(wq.size() + eq.size()), 32'd0);
    wq.delete();
    eq.delete();

    for (int t = 0; t < 30; t++) begin
      int         kind;
      int         n;
      logic [3:0] p;
      logic [7:0] s;
      bit         col;
      kind = $urandom_range(0, 5);
      p    = 4'($urandom);
      col  = 1'b0;
      pkt.delete();
      case (kind)
        0, 3, 5: begin
          pkt.push_back(8'h80);
          pkt.push_back({~p, p});
          n = (kind == 3) ? $urandom_range(MAX + 1, MAX + 2) :
              (kind == 5) ? $urandom_range(1, MAX) : $urandom_range(0, MAX);
          for (int k = 0; k < n; k++) pkt.push_back(8'($urandom));
          if (kind == 5) begin
            pkt.push_back(8'($urandom));
            col = 1'b1;
          end
        end
        1: begin
          s = 8'($urandom);
          if (s == 8'h80) s = 8'h81;
          pkt.push_back(s);
          pkt.push_back({~p, p});
        end
        2: begin
          pkt.push_back(8'h80);
          pkt.push_back({~p ^ 4'($urandom_range(1, 15)), p});
        end
        default: begin
          if ($urandom_range(0, 1) == 1) pkt.push_back(8'h80);
        end
      endcase
      applyStimulus("random", pkt, col);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
